// File: rtl/neuron_layer_if.sv
// Handshake bundle for neuron_layer_folded: input vector/weights/bias upstream,
// saturated results downstream, each side with its own valid/ready pair.
interface neuron_layer_if #(
    parameter int INPUT_WIDTH = 3,
    parameter int NUM_NEURONS = 4,
    parameter int DATA_WIDTH  = 16
);
    logic [INPUT_WIDTH-1:0][DATA_WIDTH-1:0]                  a_in;
    logic [NUM_NEURONS-1:0][INPUT_WIDTH-1:0][DATA_WIDTH-1:0] w_in;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]                  bias;
    logic                                                    in_valid;
    logic                                                    in_ready;
    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0]                  a_out;
    logic [NUM_NEURONS-1:0]                                  sat_out;
    logic                                                    out_valid;
    logic                                                    out_ready;

    modport master (
        output a_in, w_in, bias, in_valid, out_ready,
        input  in_ready, a_out, sat_out, out_valid
    );

    modport slave (
        input  a_in, w_in, bias, in_valid, out_ready,
        output in_ready, a_out, sat_out, out_valid
    );
endinterface

// File: rtl/neuron_layer_folded.sv
// Time-folded fixed-point fully-connected layer: LANES MACs per neuron per beat,
// Q-format rescale with saturation. Define NEURON_RELU_EN to clamp negative results to 0.
module neuron_layer_folded #(
    parameter int INPUT_WIDTH = 3,
    parameter int NUM_NEURONS = 4,
    parameter int LANES       = 1,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = 8,
    parameter int ACC_WIDTH   = 48
) (
    input logic           clk,
    input logic           rst,
    neuron_layer_if.slave bus
);
    localparam int BEATS  = (INPUT_WIDTH + LANES - 1) / LANES;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PROD_W = 2 * DATA_WIDTH;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] SAT_MIN =
        {{(ACC_WIDTH + 2 - DATA_WIDTH){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINISH,
        OUT
    } state_t;

    state_t                       state;
    logic [BEAT_W-1:0]            beat;
    logic signed [DATA_WIDTH-1:0] a_reg    [INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0] w_reg    [NUM_NEURONS][INPUT_WIDTH];
    logic signed [DATA_WIDTH-1:0] bias_reg [NUM_NEURONS];
    logic signed [ACC_WIDTH-1:0]  acc      [NUM_NEURONS];

    logic signed [DATA_WIDTH-1:0] lane_a    [LANES];
    logic signed [DATA_WIDTH-1:0] lane_w    [NUM_NEURONS][LANES];
    logic signed [PROD_W-1:0]     lane_prod [NUM_NEURONS][LANES];
    logic signed [ACC_WIDTH-1:0]  beat_sum  [NUM_NEURONS];

    logic signed [ACC_WIDTH:0]    biased [NUM_NEURONS];
    logic signed [ACC_WIDTH:0]    scaled [NUM_NEURONS];
    logic signed [DATA_WIDTH-1:0] result [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]       clamp;

    // Element i belongs to beat i/LANES on lane i%LANES; unmatched lanes stay zero,
    // which is how the padding slots of the final beat contribute nothing.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_a[l] = '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                lane_w[n][l] = '0;
            end
        end
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            if (beat == BEAT_W'(i / LANES)) begin
                lane_a[i % LANES] = a_reg[i];
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    lane_w[n][i % LANES] = w_reg[n][i];
                end
            end
        end
        for (int n = 0; n < NUM_NEURONS; n++) begin
            beat_sum[n] = '0;
            for (int l = 0; l < LANES; l++) begin
                lane_prod[n][l] = PROD_W'(lane_a[l]) * PROD_W'(lane_w[n][l]);
                beat_sum[n] = beat_sum[n] +
                    {{(ACC_WIDTH - PROD_W){lane_prod[n][l][PROD_W-1]}}, lane_prod[n][l]};
            end
        end
    end

    // One extra bit of headroom keeps the bias add from wrapping before the floor shift.
    always_comb begin
        for (int n = 0; n < NUM_NEURONS; n++) begin
            biased[n] = {acc[n][ACC_WIDTH-1], acc[n]} +
                ({{(ACC_WIDTH + 1 - DATA_WIDTH){bias_reg[n][DATA_WIDTH-1]}}, bias_reg[n]} << FRAC_BITS);
            scaled[n] = biased[n] >>> FRAC_BITS;
            clamp[n]  = 1'b0;
            if (scaled[n] > SAT_MAX) begin
                result[n] = {1'b0, {(DATA_WIDTH - 1){1'b1}}};
                clamp[n]  = 1'b1;
            end else if (scaled[n] < SAT_MIN) begin
                result[n] = {1'b1, {(DATA_WIDTH - 1){1'b0}}};
                clamp[n]  = 1'b1;
            end else begin
                result[n] = scaled[n][DATA_WIDTH-1:0];
            end
`ifdef NEURON_RELU_EN
            if (result[n][DATA_WIDTH-1]) begin
                result[n] = '0;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            beat          <= '0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.a_out     <= '0;
            bus.sat_out   <= '0;
            for (int n = 0; n < NUM_NEURONS; n++) begin
                acc[n] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        for (int i = 0; i < INPUT_WIDTH; i++) begin
                            a_reg[i] <= bus.a_in[i];
                        end
                        for (int n = 0; n < NUM_NEURONS; n++) begin
                            bias_reg[n] <= bus.bias[n];
                            acc[n]      <= '0;
                            for (int i = 0; i < INPUT_WIDTH; i++) begin
                                w_reg[n][i] <= bus.w_in[n][i];
                            end
                        end
                        beat         <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= ACCUM;
                    end
                end
                ACCUM: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        acc[n] <= acc[n] + beat_sum[n];
                    end
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        beat  <= '0;
                        state <= FINISH;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                FINISH: begin
                    for (int n = 0; n < NUM_NEURONS; n++) begin
                        bus.a_out[n] <= result[n];
                    end
                    bus.sat_out   <= clamp;
                    bus.out_valid <= 1'b1;
                    state         <= OUT;
                end
                OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_layer_folded.sv
// Directed bench for neuron_layer_folded: folded DUT (LANES=2, BEATS=3) plus an
// unfolded DUT (LANES=5, BEATS=1), expected values hand-computed in the vector table.
module tb_neuron_layer_folded;
    localparam int IW = 5;
    localparam int NN = 2;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int AW = 48;

    typedef struct {
        string           name;
        int              a    [IW];
        int              w    [NN][IW];
        int              bias [NN];
        int              lin  [NN];
        logic [NN-1:0]   sat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    vec_t tv [7];

`ifdef NEURON_RELU_EN
    localparam bit RELU = 1'b1;
`else
    localparam bit RELU = 1'b0;
`endif

    always #5 clk = ~clk;

    neuron_layer_if #(.INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) bus_a ();
    neuron_layer_if #(.INPUT_WIDTH(IW), .NUM_NEURONS(NN), .DATA_WIDTH(DW)) bus_b ();

    neuron_layer_folded #(
        .INPUT_WIDTH(IW), .NUM_NEURONS(NN), .LANES(2),
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW)
    ) dut_a (
        .clk(clk),
        .rst(rst),
        .bus(bus_a)
    );

    neuron_layer_folded #(
        .INPUT_WIDTH(IW), .NUM_NEURONS(NN), .LANES(5),
        .DATA_WIDTH(DW), .FRAC_BITS(FB), .ACC_WIDTH(AW)
    ) dut_b (
        .clk(clk),
        .rst(rst),
        .bus(bus_b)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    function automatic int expect_out(input int lin);
        return (RELU && lin < 0) ? 0 : lin;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        @(negedge clk);
        for (int i = 0; i < IW; i++) begin
            bus_a.a_in[i] = DW'(v.a[i]);
            for (int n = 0; n < NN; n++) begin
                bus_a.w_in[n][i] = DW'(v.w[n][i]);
            end
        end
        for (int n = 0; n < NN; n++) begin
            bus_a.bias[n] = DW'(v.bias[n]);
        end
        check({v.name, " in_ready before accept"}, int'(bus_a.in_ready), 1);
        bus_a.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_a.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus_a.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic check_output(input vec_t v);
        for (int n = 0; n < NN; n++) begin
            check($sformatf("%s a_out[%0d]", v.name, n),
                  int'($signed(bus_a.a_out[n])), expect_out(v.lin[n]));
        end
        check({v.name, " sat_out"}, int'(bus_a.sat_out), int'(v.sat));
        check({v.name, " out_valid"}, int'(bus_a.out_valid), 1);
    endtask

    task automatic release_output(input string name);
        @(negedge clk);
        bus_a.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_a.out_ready = 1'b0;
        check({name, " out_valid after handshake"}, int'(bus_a.out_valid), 0);
        check({name, " in_ready after handshake"}, int'(bus_a.in_ready), 1);
    endtask

    task automatic run_full(input vec_t v);
        int lat;
        apply_stimulus(v);
        wait_valid(lat);
        check({v.name, " latency"}, lat, 4);
        check_output(v);
        release_output(v.name);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int lat;
        tv[0].name = "unit";
        tv[0].a    = '{256, 256, 256, 256, 256};
        tv[0].w    = '{'{256, 256, 256, 256, 256}, '{256, 256, 256, 256, 256}};
        tv[0].bias = '{0, 0};
        tv[0].lin  = '{1280, 1280};
        tv[0].sat  = 2'b00;

        tv[1].name = "saturate";
        tv[1].a    = '{32767, 32767, 32767, 32767, 32767};
        tv[1].w    = '{'{32767, 32767, 32767, 32767, 32767}, '{-32767, -32767, -32767, -32767, -32767}};
        tv[1].bias = '{0, 0};
        tv[1].lin  = '{32767, -32768};
        tv[1].sat  = 2'b11;

        tv[2].name = "negative";
        tv[2].a    = '{256, 256, 256, 256, 256};
        tv[2].w    = '{'{-256, -256, -256, -256, -256}, '{-256, -256, -256, -256, -256}};
        tv[2].bias = '{0, -256};
        tv[2].lin  = '{-1280, -1536};
        tv[2].sat  = 2'b00;

        tv[3].name = "floor";
        tv[3].a    = '{1, 2, 3, 4, 5};
        tv[3].w    = '{'{1, 1, 1, 1, 1}, '{-1, -1, -1, -1, -1}};
        tv[3].bias = '{2, 0};
        tv[3].lin  = '{2, -1};
        tv[3].sat  = 2'b00;

        tv[4].name = "mixed";
        tv[4].a    = '{256, 512, -256, 768, 1024};
        tv[4].w    = '{'{256, 256, 256, 256, 256}, '{0, 0, 0, 0, 512}};
        tv[4].bias = '{256, -2560};
        tv[4].lin  = '{2560, -512};
        tv[4].sat  = 2'b00;

        tv[5].name = "bias_edge";
        tv[5].a    = '{0, 0, 0, 0, 0};
        tv[5].w    = '{'{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}};
        tv[5].bias = '{32767, -32768};
        tv[5].lin  = '{32767, -32768};
        tv[5].sat  = 2'b00;

        tv[6].name = "just_over";
        tv[6].a    = '{256, 0, 0, 0, 0};
        tv[6].w    = '{'{256, 0, 0, 0, 0}, '{-1, 0, 0, 0, 0}};
        tv[6].bias = '{32767, -32768};
        tv[6].lin  = '{32767, -32768};
        tv[6].sat  = 2'b11;

        rst             = 1'b1;
        bus_a.in_valid  = 1'b0;
        bus_a.out_ready = 1'b0;
        bus_a.a_in      = '0;
        bus_a.w_in      = '0;
        bus_a.bias      = '0;
        bus_b.in_valid  = 1'b0;
        bus_b.out_ready = 1'b0;
        bus_b.a_in      = '0;
        bus_b.w_in      = '0;
        bus_b.bias      = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", int'(bus_a.out_valid), 0);
        check("reset a_out", int'(bus_a.a_out), 0);
        check("reset sat_out", int'(bus_a.sat_out), 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-reset in_ready", int'(bus_a.in_ready), 1);

        $display("[TB] table vectors");
        for (int k = 0; k < 7; k++) begin
            run_full(tv[k]);
        end

        $display("[TB] backpressure hold");
        apply_stimulus(tv[1]);
        wait_valid(lat);
        check("hold latency", lat, 4);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            bus_a.in_valid = (c % 2 == 0);
            bus_a.a_in     = '0;
            @(posedge clk);
            #1;
            check($sformatf("hold[%0d] out_valid", c), int'(bus_a.out_valid), 1);
            check($sformatf("hold[%0d] in_ready", c), int'(bus_a.in_ready), 0);
            check($sformatf("hold[%0d] a_out[0]", c),
                  int'($signed(bus_a.a_out[0])), expect_out(32767));
            check($sformatf("hold[%0d] a_out[1]", c),
                  int'($signed(bus_a.a_out[1])), expect_out(-32768));
        end
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        release_output("hold");
        repeat (6) @(posedge clk);
        #1;
        check("ignored in_valid produced no result", int'(bus_a.out_valid), 0);

        $display("[TB] reset mid-accumulate");
        apply_stimulus(tv[2]);
        @(posedge clk);
        #1;
        pulse_reset();
        check("mid-accum reset out_valid", int'(bus_a.out_valid), 0);
        check("mid-accum reset in_ready", int'(bus_a.in_ready), 1);
        tv[0].name = "after_reset";
        run_full(tv[0]);

        $display("[TB] reset during output");
        apply_stimulus(tv[1]);
        wait_valid(lat);
        check("out-reset latency", lat, 4);
        pulse_reset();
        check("out-reset out_valid", int'(bus_a.out_valid), 0);
        check("out-reset a_out", int'(bus_a.a_out), 0);
        check("out-reset sat_out", int'(bus_a.sat_out), 0);
        check("out-reset in_ready", int'(bus_a.in_ready), 1);
        run_full(tv[4]);

        $display("[TB] unfolded instance");
        @(negedge clk);
        for (int i = 0; i < IW; i++) begin
            bus_b.a_in[i] = DW'(256);
            for (int n = 0; n < NN; n++) begin
                bus_b.w_in[n][i] = DW'(256);
            end
        end
        bus_b.bias     = '0;
        bus_b.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus_b.in_valid = 1'b0;
        lat = 0;
        while (!bus_b.out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("lanes5 latency", lat, 2);
        check("lanes5 a_out[0]", int'($signed(bus_b.a_out[0])), 1280);
        check("lanes5 a_out[1]", int'($signed(bus_b.a_out[1])), 1280);
        check("lanes5 sat_out", int'(bus_b.sat_out), 0);
        @(negedge clk);
        bus_b.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus_b.out_ready = 1'b0;
        check("lanes5 out_valid cleared", int'(bus_b.out_valid), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
